pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/mips_pipe_pkg.sv | 26 ++
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared hazard-controller types: state encoding, register-zero constant,
// counter widths and the load-use hazard compare.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int          REG_ADDR_W = 5;
    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam int          WAIT_CNT_W = 8;
    localparam int          PERF_CNT_W = 16;

    // $zero is never a real dependency, so a load into it cannot cause a stall.
    function automatic logic load_use(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] ex_rt,
        input logic [REG_ADDR_W-1:0] id_rs,
        input logic [REG_ADDR_W-1:0] id_rt
    );
        return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the optional pipeline performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// MIPS pipeline hazard controller: load-use stall, branch/jump flush and memory-wait
// freeze with timeout. Define HAZARD_PERF_EN to add the Stall_Cycles/Flush_Count ports.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] IFID_Rs,
    input  logic [REG_ADDR_W-1:0] IFID_Rt,
    input  logic [REG_ADDR_W-1:0] IDEX_Rt,
    input  logic                  IDEX_MemRead,
    input  logic                  Branch_Taken,
    input  logic                  Jump,
    input  logic                  Mem_Busy,
    output logic                  PC_Write,
    output logic                  IFID_Enable,
    output logic                  IFID_Flush,
    output logic                  IDEX_Bubble,
    output logic                  Pipe_Freeze,
    output logic                  Mem_Timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] Stall_Cycles,
    output logic [PERF_CNT_W-1:0] Flush_Count
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

    hz_state_t             r_state;
    hz_state_t             w_state_next;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_next;
    logic                  r_timeout;
    logic                  w_timeout_set;
    logic                  w_busy;
    logic                  w_hazard;
    logic                  w_redirect;
    logic                  w_pc_write;
    logic                  w_ifid_en;
    logic                  w_flush;
    logic                  w_bubble;
    logic                  w_freeze;

    // After a timeout the memory is treated as failed: Mem_Busy no longer freezes.
    assign w_busy     = Mem_Busy && !r_timeout;
    assign w_hazard   = load_use(IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt);
    assign w_redirect = Branch_Taken || Jump;

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_timeout_set   = 1'b0;
        w_pc_write      = 1'b1;
        w_ifid_en       = 1'b1;
        w_flush         = 1'b0;
        w_bubble        = 1'b0;
        w_freeze        = 1'b0;
        if (reset) begin
            case (r_state)
                ST_RUN, ST_LU_STALL: begin
                    if (w_busy) begin
                        w_pc_write      = 1'b0;
                        w_ifid_en       = 1'b0;
                        w_freeze        = 1'b1;
                        w_wait_cnt_next = '0;
                        w_state_next    = ST_MEM_WAIT;
                    end else if ((r_state == ST_RUN) && w_hazard) begin
                        // A coincident branch is dropped; it is seen again next cycle.
                        w_pc_write   = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_bubble     = 1'b1;
                        w_state_next = ST_LU_STALL;
                    end else begin
                        w_flush      = w_redirect;
                        w_state_next = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_busy) begin
                        w_pc_write      = 1'b0;
                        w_ifid_en       = 1'b0;
                        w_freeze        = 1'b1;
                        w_wait_cnt_next = r_wait_cnt + WAIT_CNT_W'(1);
                        if (r_wait_cnt == WAIT_LAST) begin
                            w_timeout_set = 1'b1;
                            w_state_next  = ST_RUN;
                        end
                    end else begin
                        w_flush      = w_redirect;
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_timeout  <= r_timeout || w_timeout_set;
        end
    end

    assign PC_Write    = w_pc_write;
    assign IFID_Enable = w_ifid_en;
    assign IFID_Flush  = w_flush;
    assign IDEX_Bubble = w_bubble;
    assign Pipe_Freeze = w_freeze;
    assign Mem_Timeout = r_timeout;

`ifdef HAZARD_PERF_EN
    sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (!w_pc_write),
        .o_count (Stall_Cycles)
    );

    sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_flush),
        .o_count (Flush_Count)
    );
`endif

endmodule
